tx_frame_scheduler: RTL and testbench

//  Per-TX-port frame scheduler for the 4x4 crossbar: one instance per TX port.

---
 rtl/tx_frame_scheduler_pkg.sv | 8 +
 rtl/tx_frame_scheduler_if.sv | 14 +
 rtl/tx_frame_scheduler_rr_arbiter_core.sv | 19 +
 rtl/tx_frame_scheduler.sv | 100 ++++++++++
 tb/tb_tx_frame_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_frame_scheduler_pkg.sv
// tx_frame_scheduler_pkg: shared crossbar constants and scheduler state type.
package tx_frame_scheduler_pkg;
   localparam int N_PORTS    = 4;
   localparam int N_VC       = N_PORTS - 1;
   localparam int IFG_CYCLES = 12;
   localparam int MAX_FRAME  = 1518;
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} sched_state_e;
endpackage

// File: rtl/tx_frame_scheduler_if.sv
// tx_frame_scheduler_if: VC-queue read side and TX mux controls of one TX port.
interface tx_frame_scheduler_if
   import tx_frame_scheduler_pkg::*;
#(parameter int N_REQ = N_VC);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] eof;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] rd_en;
   logic             tx_ctrl;
   logic             busy;
   logic             err;
   modport master (input req, eof, output grant, rd_en, tx_ctrl, busy, err);
   modport slave  (output req, eof, input grant, rd_en, tx_ctrl, busy, err);
endinterface

// File: rtl/tx_frame_scheduler_rr_arbiter_core.sv
// rr_arbiter_core: combinational rotate-priority pick, first request at index >= ptr, wrapping.
module rr_arbiter_core #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          valid
);
   logic [N-1:0] hi;
   logic [N-1:0] sel;
   always_comb begin
      hi    = req & ~((N'(1) << ptr) - N'(1));
      sel   = (|hi) ? hi : req;
      gnt   = sel & (~sel + N'(1));
      valid = |req;
   end
endmodule

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: grants whole frames round-robin to one TX port, pops to eof,
// then holds the inter-frame gap; a length watchdog aborts runaway frames.
module tx_frame_scheduler
   import tx_frame_scheduler_pkg::*;
#(
   parameter int P_N_REQ   = N_VC,
   parameter int P_IFG     = IFG_CYCLES,
   parameter int P_MAX_LEN = MAX_FRAME
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   tx_frame_scheduler_if.master bus
);
   localparam int PW = (P_N_REQ > 1) ? $clog2(P_N_REQ) : 1;
   localparam int LW = $clog2(P_MAX_LEN + 1);
   localparam int GW = (P_IFG > 1) ? $clog2(P_IFG) : 1;
   localparam logic [GW-1:0] GAP_INIT = GW'((P_IFG > 0) ? P_IFG - 1 : 0);
   localparam logic [LW-1:0] LEN_LAST = LW'(P_MAX_LEN - 1);

   sched_state_e       state_q, state_d;
   logic [P_N_REQ-1:0] grant_q, grant_d;
   logic [PW-1:0]      ptr_q, ptr_d, ptr_nxt;
   logic [LW-1:0]      len_q, len_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic               tx_q;
   logic [P_N_REQ-1:0] arb_gnt;
   logic               arb_valid;
   logic [P_N_REQ-1:0] rd_en;
   logic               last_pop;
   logic               wd_hit;

   rr_arbiter_core #(.N(P_N_REQ), .PW(PW)) u_arb (
      .req   (bus.req),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .valid (arb_valid)
   );

   assign last_pop = |(grant_q & bus.eof);
   // len_q holds pops already done, so LEN_LAST marks the P_MAX_LEN-th pop
   assign wd_hit   = len_q == LEN_LAST;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         tx_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         tx_q    <= |rd_en;
      end
   end

   always_comb begin
      ptr_nxt = '0;
      for (int i = 0; i < P_N_REQ; i++)
         if (grant_q[i]) ptr_nxt = (i == P_N_REQ - 1) ? '0 : PW'(i + 1);
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: if (arb_valid) begin
            state_d = S_SEND;
            grant_d = arb_gnt;
            len_d   = '0;
         end
         S_SEND: if (last_pop || wd_hit) begin
            state_d = (P_IFG == 0) ? S_IDLE : S_GAP;
            grant_d = '0;
            gap_d   = GAP_INIT;
            ptr_d   = ptr_nxt;
         end else begin
            len_d   = len_q + LW'(1);
         end
         S_GAP: begin
            gap_d   = (gap_q == '0) ? '0 : gap_q - GW'(1);
            state_d = (gap_q == '0) ? S_IDLE : S_GAP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_en       = (state_q == S_SEND) ? grant_q : '0;
      bus.rd_en   = rd_en;
      bus.grant   = grant_q;
      bus.tx_ctrl = tx_q;
      bus.busy    = state_q != S_IDLE;
      bus.err     = (state_q == S_SEND) && wd_hit && !last_pop;
   end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: arbitration table, frame-level schedule model with random frames,
// watchdog and async reset sequences, for IFG=12 and IFG=0 instances.
module tb_tx_frame_scheduler;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] req = '0;
   logic [2:0] eof = '0;
   bit         sel = 1'b0;
   bit         emu = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         flen [3][8];
   int         fcnt [3];
   int         fhead [3];
   int         popped [3];

   always #5 clk = ~clk;

   tx_frame_scheduler_if #(.N_REQ(3)) ifa ();
   tx_frame_scheduler_if #(.N_REQ(3)) ifz ();
   assign ifa.req = req;
   assign ifa.eof = eof;
   assign ifz.req = req;
   assign ifz.eof = eof;

   tx_frame_scheduler #(.P_N_REQ(3), .P_IFG(12), .P_MAX_LEN(1518)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus(ifa));
   tx_frame_scheduler #(.P_N_REQ(3), .P_IFG(0), .P_MAX_LEN(1518)) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .bus(ifz));

   logic [2:0] s_grant, s_rd;
   logic       s_tx, s_busy, s_err;
   assign s_grant = sel ? ifz.grant   : ifa.grant;
   assign s_rd    = sel ? ifz.rd_en   : ifa.rd_en;
   assign s_tx    = sel ? ifz.tx_ctrl : ifa.tx_ctrl;
   assign s_busy  = sel ? ifz.busy    : ifa.busy;
   assign s_err   = sel ? ifz.err     : ifa.err;

   typedef struct {
      int         prev;
      logic [2:0] rq;
      logic [2:0] exp;
   } arb_vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   // queue emulation: req = a complete frame is waiting, eof = head byte is its last
   task automatic emu_drive();
      for (int v = 0; v < 3; v++) begin
         req[v] = fhead[v] < fcnt[v];
         eof[v] = req[v] && (popped[v] == flen[v][fhead[v]] - 1);
      end
   endtask

   task automatic emu_update(input logic [2:0] rp);
      for (int v = 0; v < 3; v++)
         if (rp[v] && fhead[v] < fcnt[v]) begin
            popped[v]++;
            if (popped[v] == flen[v][fhead[v]]) begin
               fhead[v]++;
               popped[v] = 0;
            end
         end
      emu_drive();
   endtask

   task automatic tick();
      logic [2:0] rp;
      rp = s_rd;
      @(negedge clk);
      cyc++;
      if (emu) emu_update(rp);
      #1;
   endtask

   task automatic do_reset();
      emu = 1'b0;
      req = '0;
      eof = '0;
      for (int v = 0; v < 3; v++) begin
         fcnt[v] = 0;
         fhead[v] = 0;
         popped[v] = 0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   // frame-level model: rotate from ptr over VCs with frames, next first pop = last pop + ifg + 2
   task automatic run_sched(input int ifg);
      logic [2:0] er [0:511];
      bit         eb [0:511];
      int         h [3];
      int         t, p, e, last, len, endr, vsel, vv;
      bit         found;
      for (int i = 0; i < 512; i++) begin
         er[i] = '0;
         eb[i] = 1'b0;
      end
      for (int v = 0; v < 3; v++) h[v] = 0;
      t = 1;
      p = 0;
      last = 0;
      vsel = 0;
      do begin
         found = 1'b0;
         for (int k = 0; k < 3; k++) begin
            vv = (p + k) % 3;
            if (!found && h[vv] < fcnt[vv]) begin
               found = 1'b1;
               vsel = vv;
            end
         end
         if (found) begin
            len = flen[vsel][h[vsel]];
            h[vsel]++;
            for (int k = 0; k < len; k++) begin
               er[t + k] = 3'(1 << vsel);
               eb[t + k] = 1'b1;
            end
            e = t + len - 1;
            for (int k = 1; k <= ifg; k++) eb[e + k] = 1'b1;
            t = e + ifg + 2;
            p = (vsel + 1) % 3;
            last = e;
         end
      end while (found);
      endr = last + ifg + 3;
      emu = 1'b1;
      emu_drive();
      #1;
      chk("sched_idle_rd", 32'(s_rd), 32'(0));
      for (int r = 1; r <= endr; r++) begin
         tick();
         chk("sched_rd", 32'(s_rd), 32'(er[r]));
         chk("sched_grant", 32'(s_grant), 32'(er[r]));
         chk("sched_tx", 32'(s_tx), 32'(|er[r - 1]));
         chk("sched_busy", 32'(s_busy), 32'(eb[r]));
         chk("sched_err", 32'(s_err), 32'(0));
      end
      for (int v = 0; v < 3; v++) chk("sched_drained", 32'(fhead[v]), 32'(fcnt[v]));
      emu = 1'b0;
   endtask

   task automatic wd_run(input bit with_eof);
      int n, pops, errs, err_at;
      n = 0;
      pops = 0;
      errs = 0;
      err_at = 0;
      do_reset();
      sel = 1'b0;
      req = 3'b001;
      #1;
      while (s_rd == '0 && n < 30) begin
         tick();
         n++;
      end
      chk("wd_start", 32'(s_rd), 32'(1));
      while (s_rd != '0 && n < 2000) begin
         pops++;
         if (with_eof && pops == 1518) begin
            eof = 3'b001;
            #1;
         end
         if (s_err) begin
            errs++;
            err_at = pops;
         end
         tick();
         n++;
      end
      chk("wd_pops", 32'(pops), 32'(1518));
      chk("wd_err_pulses", 32'(errs), with_eof ? 32'(0) : 32'(1));
      if (!with_eof) chk("wd_err_at", 32'(err_at), 32'(1518));
      chk("wd_grant_after", 32'(s_grant), 32'(0));
      chk("wd_busy_gap", 32'(s_busy), 32'(1));
      chk("wd_err_after", 32'(s_err), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      arb_vec_t tbl [11];
      int n;
      tbl[0]  = '{-1, 3'b001, 3'b001};
      tbl[1]  = '{-1, 3'b111, 3'b001};
      tbl[2]  = '{-1, 3'b110, 3'b010};
      tbl[3]  = '{-1, 3'b100, 3'b100};
      tbl[4]  = '{ 0, 3'b111, 3'b010};
      tbl[5]  = '{ 0, 3'b101, 3'b100};
      tbl[6]  = '{ 1, 3'b101, 3'b100};
      tbl[7]  = '{ 1, 3'b011, 3'b001};
      tbl[8]  = '{ 2, 3'b110, 3'b010};
      tbl[9]  = '{ 2, 3'b100, 3'b100};
      tbl[10] = '{ 0, 3'b001, 3'b001};

      #2;
      rst_n = 1'b0;
      #1;
      sel = 1'b0;
      chk("rst_grant", 32'(s_grant), 32'(0));
      chk("rst_rd", 32'(s_rd), 32'(0));
      chk("rst_tx", 32'(s_tx), 32'(0));
      chk("rst_busy", 32'(s_busy), 32'(0));
      chk("rst_err", 32'(s_err), 32'(0));

      for (int i = 0; i < 11; i++) begin
         do_reset();
         sel = 1'b0;
         if (tbl[i].prev >= 0) begin
            fcnt[tbl[i].prev] = 1;
            flen[tbl[i].prev][0] = 1;
            emu = 1'b1;
            emu_drive();
            repeat (20) tick();
            emu = 1'b0;
         end
         req = tbl[i].rq;
         eof = '0;
         #1;
         n = 0;
         while (s_grant == '0 && n < 40) begin
            tick();
            n++;
         end
         chk($sformatf("arb%0d", i), 32'(s_grant), 32'(tbl[i].exp));
      end

      do_reset();
      sel = 1'b0;
      fcnt[0] = 1;
      flen[0][0] = 64;
      run_sched(12);

      do_reset();
      sel = 1'b0;
      fcnt[0] = 2; fcnt[1] = 1; fcnt[2] = 1;
      flen[0][0] = 5; flen[1][0] = 7; flen[2][0] = 3; flen[0][1] = 4;
      run_sched(12);

      do_reset();
      sel = 1'b1;
      fcnt[0] = 1; fcnt[1] = 1;
      flen[0][0] = 5; flen[1][0] = 4;
      run_sched(0);

      for (int tr = 0; tr < 6; tr++) begin
         do_reset();
         sel = tr[0];
         for (int v = 0; v < 3; v++) begin
            fcnt[v] = int'($urandom_range(0, 3));
            for (int f = 0; f < 8; f++) flen[v][f] = int'($urandom_range(1, 20));
         end
         if (fcnt[0] + fcnt[1] + fcnt[2] == 0) fcnt[0] = 1;
         run_sched(sel ? 0 : 12);
      end

      wd_run(1'b0);
      wd_run(1'b1);

      do_reset();
      sel = 1'b0;
      req = 3'b001;
      #1;
      n = 0;
      while (s_rd == '0 && n < 30) begin
         tick();
         n++;
      end
      repeat (5) tick();
      chk("ar_pre_tx", 32'(s_tx), 32'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_grant", 32'(s_grant), 32'(0));
      chk("ar_rd", 32'(s_rd), 32'(0));
      chk("ar_tx", 32'(s_tx), 32'(0));
      chk("ar_busy", 32'(s_busy), 32'(0));
      chk("ar_err", 32'(s_err), 32'(0));
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      req = 3'b010;
      #1;
      n = 0;
      while (s_grant == '0 && n < 30) begin
         tick();
         n++;
      end
      chk("ar_regrant", 32'(s_grant), 32'(3'b010));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
